truth_table_sweeper: RTL and testbench

Sequencer that exercises a 3-input combinational function block (the Mux2/Mux4/Mux8-based truth-table implementations) by stepping its select/variable lines through every input combination. It samples the block's Y output at each combination, assembles the measured truth table, and compares it against an expected table. It reports pass/fail, mismatch count and first failing index. It sits between the lab's switch/button inputs and the mux implementations, and can be shared by any of the table circuits.

---
 rtl/truth_table_sweeper.sv | 149 ++++++++++++++
 tb/tb_truth_table_sweeper.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// Steps the select lines of a small combinational block through every input
// combination, records its output and compares the measured truth table with an expected one.
module truth_table_sweeper #(
  parameter int N_VAR  = 3,
  parameter int SETTLE = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_start,
  input  logic                    i_abort,
  input  logic [(2**N_VAR)-1:0]   i_expected,
  input  logic                    i_y_dut,
  output logic [N_VAR-1:0]        o_sel,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_pass,
  output logic [(2**N_VAR)-1:0]   o_table,
  output logic [N_VAR:0]          o_mismatch_count,
  output logic [N_VAR-1:0]        o_first_fail,
  output logic                    o_first_fail_valid
);

  localparam int TBL_W = 2**N_VAR;
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'((SETTLE > 0) ? (SETTLE - 1) : 0);
  localparam logic [N_VAR-1:0] LAST_IDX    = {N_VAR{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  // With no settle time a freshly driven index is sampled on the very next edge.
  localparam state_t DRIVE_NEXT = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [N_VAR-1:0]   r_sel;
  logic [TBL_W-1:0]   r_expected;
  logic [TBL_W-1:0]   r_table;
  logic [N_VAR:0]     r_mismatch;
  logic [N_VAR-1:0]   r_first_fail;
  logic               r_first_fail_valid;
  logic               r_busy;
  logic               r_done;
  logic               r_pass;

  logic               w_miss;
  logic               w_last;

  assign w_miss = i_y_dut ^ r_expected[r_sel];
  assign w_last = (r_sel == LAST_IDX);

  // Sweep sequencer: drives sel, captures y_dut and accumulates the comparison result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state            <= S_IDLE;
      r_cnt              <= {CNT_W{1'b0}};
      r_sel              <= {N_VAR{1'b0}};
      r_expected         <= {TBL_W{1'b0}};
      r_table            <= {TBL_W{1'b0}};
      r_mismatch         <= {(N_VAR+1){1'b0}};
      r_first_fail       <= {N_VAR{1'b0}};
      r_first_fail_valid <= 1'b0;
      r_busy             <= 1'b0;
      r_done             <= 1'b0;
      r_pass             <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_expected         <= i_expected;
            r_table            <= {TBL_W{1'b0}};
            r_mismatch         <= {(N_VAR+1){1'b0}};
            r_first_fail       <= {N_VAR{1'b0}};
            r_first_fail_valid <= 1'b0;
            r_pass             <= 1'b0;
            r_sel              <= {N_VAR{1'b0}};
            r_busy             <= 1'b1;
            r_cnt              <= SETTLE_LOAD;
            r_state            <= DRIVE_NEXT;
          end
        end
        S_SETTLE: begin
          if (i_abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_sel   <= {N_VAR{1'b0}};
            r_pass  <= 1'b0;
          end else if (r_cnt == {CNT_W{1'b0}}) begin
            r_state <= S_SAMPLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1'b1);
          end
        end
        S_SAMPLE: begin
          // Abort wins over the capture scheduled for this edge.
          if (i_abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_sel   <= {N_VAR{1'b0}};
            r_pass  <= 1'b0;
          end else begin
            r_table[r_sel] <= i_y_dut;
            if (w_miss) begin
              r_mismatch <= r_mismatch + (N_VAR+1)'(1'b1);
              if (!r_first_fail_valid) begin
                r_first_fail       <= r_sel;
                r_first_fail_valid <= 1'b1;
              end
            end
            if (!w_last) begin
              r_sel   <= r_sel + N_VAR'(1'b1);
              r_cnt   <= SETTLE_LOAD;
              r_state <= DRIVE_NEXT;
            end else begin
              r_state <= S_FINISH;
            end
          end
        end
        S_FINISH: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_pass  <= (r_mismatch == {(N_VAR+1){1'b0}});
          r_sel   <= {N_VAR{1'b0}};
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_sel   <= {N_VAR{1'b0}};
        end
      endcase
    end
  end

  assign o_sel              = r_sel;
  assign o_busy             = r_busy;
  assign o_done             = r_done;
  assign o_pass             = r_pass;
  assign o_table            = r_table;
  assign o_mismatch_count   = r_mismatch;
  assign o_first_fail       = r_first_fail;
  assign o_first_fail_valid = r_first_fail_valid;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: default instance (SETTLE=1) plus a SETTLE=0 instance.
module tb_truth_table_sweeper;

  logic       clk;
  logic       rst_n;
  logic       start0, abort0, start1, abort1;
  logic [7:0] exp0, exp1;
  logic       y0, y1;
  int         mode;

  logic [2:0] sel0, sel1;
  logic       busy0, busy1, done0, done1, pass0, pass1;
  logic [7:0] tbl0, tbl1;
  logic [3:0] mm0, mm1;
  logic [2:0] ff0, ff1;
  logic       ffv0, ffv1;

  int total = 0;
  int bad   = 0;
  int n;

  truth_table_sweeper #(.N_VAR(3), .SETTLE(1)) u0 (
    .clk(clk), .rst_n(rst_n), .i_start(start0), .i_abort(abort0),
    .i_expected(exp0), .i_y_dut(y0), .o_sel(sel0), .o_busy(busy0),
    .o_done(done0), .o_pass(pass0), .o_table(tbl0), .o_mismatch_count(mm0),
    .o_first_fail(ff0), .o_first_fail_valid(ffv0)
  );

  truth_table_sweeper #(.N_VAR(3), .SETTLE(0)) u1 (
    .clk(clk), .rst_n(rst_n), .i_start(start1), .i_abort(abort1),
    .i_expected(exp1), .i_y_dut(y1), .o_sel(sel1), .o_busy(busy1),
    .o_done(done1), .o_pass(pass1), .o_table(tbl1), .o_mismatch_count(mm1),
    .o_first_fail(ff1), .o_first_fail_valid(ffv1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Function block model: 0 = A^B^C, 1 = stuck at 0, 2 = stuck at 1.
  always_comb begin
    y0 = 1'b0;
    case (mode)
      0:       y0 = ^sel0;
      1:       y0 = 1'b0;
      2:       y0 = 1'b1;
      default: y0 = 1'b0;
    endcase
  end
  assign y1 = 1'b1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic wait_done(input bit which, input int from, output int cnt);
    cnt = from;
    while (((which ? done1 : done0) !== 1'b1) && cnt < 60) begin
      step();
      cnt++;
    end
  endtask

  initial begin
    rst_n = 1'b0; start0 = 1'b0; abort0 = 1'b0; start1 = 1'b0; abort1 = 1'b0;
    exp0 = 8'h00; exp1 = 8'h00; mode = 0;
    #12;
    chk("rst_busy", busy0, 1'b0);
    chk("rst_sel", sel0, 3'd0);
    chk("rst_done", done0, 1'b0);
    chk("rst_pass", pass0, 1'b0);
    chk("rst_table", tbl0, 8'h00);
    chk("rst_mm", mm0, 4'd0);
    chk("rst_ffv", ffv0, 1'b0);
    @(posedge clk); #2 rst_n = 1'b1;
    step();

    // Sweep 1: XOR model matches 8'h96
    exp0 = 8'h96; mode = 0; start0 = 1'b1;
    step();
    start0 = 1'b0;
    chk("t1_busy_start", busy0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk("t1_sel_a", sel0, i[2:0]);
      step();
      chk("t1_sel_b", sel0, i[2:0]);
      step();
    end
    chk("t1_busy_fin", busy0, 1'b1);
    chk("t1_done_early", done0, 1'b0);
    step();
    chk("t1_done", done0, 1'b1);
    chk("t1_busy_end", busy0, 1'b0);
    chk("t1_table", tbl0, 8'h96);
    chk("t1_pass", pass0, 1'b1);
    chk("t1_mm", mm0, 4'd0);
    chk("t1_ffv", ffv0, 1'b0);
    chk("t1_sel_end", sel0, 3'd0);
    step();
    chk("t1_done_pulse", done0, 1'b0);

    // Sweep 2: stuck-at-0
    mode = 1; start0 = 1'b1;
    step();
    start0 = 1'b0;
    wait_done(1'b0, 0, n);
    chk("t2_latency", n, 17);
    chk("t2_table", tbl0, 8'h00);
    chk("t2_mm", mm0, 4'd4);
    chk("t2_ff", ff0, 3'd1);
    chk("t2_ffv", ffv0, 1'b1);
    chk("t2_pass", pass0, 1'b0);

    // Sweep 3: abort in SAMPLE at sel=3 with XOR model
    mode = 0; start0 = 1'b1;
    step();
    start0 = 1'b0;
    repeat (7) step();
    chk("t3_sel3", sel0, 3'd3);
    abort0 = 1'b1;
    step();
    abort0 = 1'b0;
    chk("t3_busy", busy0, 1'b0);
    chk("t3_sel", sel0, 3'd0);
    chk("t3_table", tbl0, 8'h06);
    chk("t3_pass", pass0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("t3_no_done", done0, 1'b0);
      step();
    end

    // Sweep 3b: stuck-at-1, abort at sel=3 must not capture index 3
    mode = 2; start0 = 1'b1;
    step();
    start0 = 1'b0;
    repeat (7) step();
    abort0 = 1'b1;
    step();
    abort0 = 1'b0;
    chk("t3b_table", tbl0, 8'h07);
    chk("t3b_mm", mm0, 4'd1);
    chk("t3b_ff", ff0, 3'd0);
    chk("t3b_ffv", ffv0, 1'b1);
    chk("t3b_busy", busy0, 1'b0);

    // Sweep 4: start re-pulsed mid-sweep, then held through FINISH
    mode = 0; start0 = 1'b1;
    step();
    start0 = 1'b0;
    repeat (8) step();
    chk("t4_sel4", sel0, 3'd4);
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    chk("t4_busy_mid", busy0, 1'b1);
    repeat (7) step();
    chk("t4_done_early", done0, 1'b0);
    start0 = 1'b1;
    step();
    chk("t4_done", done0, 1'b1);
    chk("t4_table", tbl0, 8'h96);
    chk("t4_pass", pass0, 1'b1);
    chk("t4_busy_end", busy0, 1'b0);
    step();
    chk("t4_restart_busy", busy0, 1'b1);
    chk("t4_restart_done", done0, 1'b0);
    chk("t4_restart_pass", pass0, 1'b0);
    chk("t4_restart_table", tbl0, 8'h00);

    // Sweep 5: async reset while sel=5
    start0 = 1'b0;
    repeat (10) step();
    chk("t5_sel5", sel0, 3'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_busy", busy0, 1'b0);
    chk("t5_sel", sel0, 3'd0);
    chk("t5_table", tbl0, 8'h00);
    chk("t5_pass", pass0, 1'b0);
    chk("t5_mm", mm0, 4'd0);
    chk("t5_done", done0, 1'b0);
    @(posedge clk); #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_idle_busy", busy0, 1'b0);
      chk("t5_idle_done", done0, 1'b0);
    end

    // Sweep 6: SETTLE=0 instance, all ones
    exp1 = 8'hFF; start1 = 1'b1;
    step();
    start1 = 1'b0;
    chk("t6_sel0", sel1, 3'd0);
    chk("t6_busy", busy1, 1'b1);
    step();
    chk("t6_sel1", sel1, 3'd1);
    wait_done(1'b1, 1, n);
    chk("t6_latency", n, 9);
    chk("t6_table", tbl1, 8'hFF);
    chk("t6_pass", pass1, 1'b1);
    chk("t6_mm", mm1, 4'd0);
    chk("t6_busy_end", busy1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
